// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: carries PC, instruction and sideband tag from fetch
// to decode behind a valid/ready handshake, with flush and an optional skid buffer.
module if_id_pipe_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TAG_WIDTH  = 4,
  parameter bit                    SKID_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [1:0]            state
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // Handshake: a beat moves on an edge where valid && ready are both high;
  // valid never depends on ready, and a presented payload is held until taken.
  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic [1:0]            state_q;
      logic [1:0]            state_d;
      logic                  ready_q;
      logic [DATA_WIDTH-1:0] skid_pc;
      logic [DATA_WIDTH-1:0] skid_instr;
      logic [TAG_WIDTH-1:0]  skid_tag;
      logic                  load_main_in;
      logic                  load_main_skid;
      logic                  load_skid;

      always_comb begin
        state_d = state_q;
        case (state_q)
          ST_EMPTY: if (in_fire) state_d = ST_BUSY;
          ST_BUSY: begin
            if (in_fire && !out_fire)      state_d = ST_FULL;
            else if (!in_fire && out_fire) state_d = ST_EMPTY;
          end
          ST_FULL:  if (out_fire) state_d = ST_BUSY;
          default:  state_d = ST_EMPTY;
        endcase
      end

      // Outputs always come from the main register; the skid slot only
      // catches the beat accepted while ID was stalling.
      assign load_main_in   = in_fire && ((state_q == ST_EMPTY) || ((state_q == ST_BUSY) && out_fire));
      assign load_skid      = in_fire && (state_q == ST_BUSY) && !out_fire;
      assign load_main_skid = (state_q == ST_FULL) && out_fire;

      always_ff @(posedge clk) begin
        if (!rst) begin
          state_q    <= ST_EMPTY;
          ready_q    <= 1'b1;
          out_pc     <= RESET_PC;
          out_instr  <= NOP_INSTR;
          out_tag    <= '0;
          skid_pc    <= '0;
          skid_instr <= '0;
          skid_tag   <= '0;
        end else if (flush) begin
          state_q   <= ST_EMPTY;
          ready_q   <= 1'b1;
          out_instr <= NOP_INSTR;
          out_tag   <= '0;
        end else begin
          state_q <= state_d;
          ready_q <= (state_d != ST_FULL);
          if (load_main_in) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
            out_tag   <= in_tag;
          end else if (load_main_skid) begin
            out_pc    <= skid_pc;
            out_instr <= skid_instr;
            out_tag   <= skid_tag;
          end
          if (load_skid) begin
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
            skid_tag   <= in_tag;
          end
        end
      end

      assign in_ready  = ready_q;
      assign out_valid = (state_q != ST_EMPTY);
      assign state     = state_q;
    end else begin : g_single
      logic valid_q;

      // Ready looks through to ID so a full register can refill on the same edge it drains.
      assign in_ready = !valid_q || out_ready;

      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_q   <= 1'b0;
          out_pc    <= RESET_PC;
          out_instr <= NOP_INSTR;
          out_tag   <= '0;
        end else if (flush) begin
          valid_q   <= 1'b0;
          out_instr <= NOP_INSTR;
          out_tag   <= '0;
        end else if (in_fire) begin
          valid_q   <= 1'b1;
          out_pc    <= in_pc;
          out_instr <= in_instr;
          out_tag   <= in_tag;
        end else if (out_fire) begin
          valid_q <= 1'b0;
        end
      end

      assign out_valid = valid_q;
      assign state     = valid_q ? ST_BUSY : ST_EMPTY;
    end
  endgenerate

  a_payload_stable: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready && !flush) |=> $stable({out_pc, out_instr, out_tag}));

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Parametrised IF/ID pipeline register for the 5-stage core. It carries PC, instruction and a sideband tag from fetch to decode.
- Provides a valid/ready handshake, a flush for branch/jump redirect, and an optional 2-entry skid buffer.
- With the skid buffer enabled, in_ready is a registered signal, which cuts the combinational ready path from ID back to IF.
- Replaces the unconditional always-enabled IF/ID register.

Parameters:
- DATA_WIDTH, 32: width of PC and instruction.
- TAG_WIDTH, 4: sideband width (exception cause / predicted-taken bits). Minimum 1.
- SKID_EN, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- RESET_PC, 32'h8000_0000: out_pc value after reset.
- NOP_INSTR, 32'h0000_0013: instruction loaded on reset and on flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  IF presents an entry.
- in_ready  out  1  stage can accept; transfer happens when in_valid && in_ready.
- in_pc  in  DATA_WIDTH  fetch PC.
- in_instr  in  DATA_WIDTH  fetched instruction.
- in_tag  in  TAG_WIDTH  sideband.
- out_valid  out  1  entry presented to ID.
- out_ready  in  1  ID accepts; transfer happens when out_valid && out_ready.
- out_pc  out  DATA_WIDTH  held PC.
- out_instr  out  DATA_WIDTH  held instruction.
- out_tag  out  TAG_WIDTH  held sideband.

Behaviour:
- Reset (rst==0 at a clock edge):
  - out_valid=0, out_pc=RESET_PC, out_instr=NOP_INSTR, out_tag=0.
  - Skid buffer invalid; state EMPTY; in_ready=1 from the first cycle after reset.
  - Reset overrides flush and both handshakes. Reset in mid-operation drops all entries.
- Priority at each edge: reset > flush > handshake.
- Flush:
  - Next cycle: out_valid=0, skid invalid, state EMPTY, out_instr=NOP_INSTR, out_tag=0, out_pc holds its value.
  - An input transferred in the flush cycle is discarded.
  - in_ready=1 in the cycle after the flush.
- SKID_EN=1, state machine. Outputs always come from the main register. in_ready = (state != FULL), registered.
  - EMPTY: out_valid=0. in_fire -> BUSY, main <= input.
  - BUSY: out_valid=1.
    - in_fire && out_fire -> BUSY, main <= input.
    - in_fire && !out_fire -> FULL, skid <= input.
    - !in_fire && out_fire -> EMPTY.
    - Otherwise hold.
  - FULL: out_valid=1, in_ready=0.
    - out_fire -> BUSY, main <= skid.
    - Otherwise hold.
  - No entry is lost or duplicated. Order is strict FIFO. Latency is 1 cycle from in_fire to out_valid when the stage is empty.
  - Throughput is 1/cycle with out_ready held high.
- SKID_EN=0:
  - Single main register. in_ready = !out_valid || out_ready (combinational).
  - in_fire loads main and sets out_valid.
  - out_fire without in_fire clears out_valid.
- Payload stability: while out_valid=1 and out_ready=0, out_pc, out_instr and out_tag do not change.
- No arithmetic is performed; all fields pass through at full width with no truncation.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_pc=0x80000000, out_instr=0x00000013, in_ready=1 after release.
2. Streaming: out_ready=1, feed PC 0x80000000/0x80000004/0x80000008 on consecutive cycles -> same three appear on out_* one cycle later, back-to-back, out_valid continuously 1.
3. Backpressure (SKID_EN=1): out_ready=0 after the first entry, send 0x80000000 and 0x80000004 -> state FULL, in_ready=0 next cycle, out_pc holds 0x80000000. Raise out_ready -> 0x80000000 then 0x80000004 delivered in order, none lost.
4. Flush in FULL: entries 0x80000010/0x80000014 held, assert flush with in_valid=1 (PC 0x80000018) -> next cycle out_valid=0, out_instr=0x00000013, in_ready=1; 0x80000018 never appears on the output.
5. Simultaneous events in BUSY: in_fire && out_fire on the same edge with PC 0x80000020 -> next cycle out_pc=0x80000020, state BUSY, skid still invalid.
6. SKID_EN=0 build: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle, and a new entry is accepted on that edge.
